// File: rtl/tdm_deser.sv
// rtl/tdm_deser.sv - TDM-to-parallel deserializer with valid/ready frame output.
// Optional fs realignment checker enabled by defining TDM_FS_CHECK_EN.
module tdm_deser #(
    parameter int CHANNELS = 8,
    parameter int SLOT_W   = 32,
    parameter int DATA_W   = 24,
    parameter int EDGE_W   = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic                         fs_delay,
    input  logic [EDGE_W-1:0]            clk_patt,
    input  logic [EDGE_W-1:0]            clk_mask,
    input  logic                         sclk,
    input  logic                         fs,
    input  logic                         tdmin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         overrun,
    output logic                         frame_err
);
    localparam int FW = CHANNELS * DATA_W;
    localparam int BW = $clog2(SLOT_W);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
    state_t state, state_nxt;

    logic [EDGE_W-1:0] samp;
    logic              level, fs_prev, dly, frame_done;
    logic [BW-1:0]     bit_cnt, bit_base, bit_nxt;
    logic [CW-1:0]     slot_cnt, slot_base, slot_nxt;
    logic [FW-1:0]     shadow, shadow_base, shadow_nxt;
    logic              rise, fall, fs_rise, at_last;
    logic              restart, capture, done, fs_bad;

    assign rise    = !level && ((samp & clk_mask) == (clk_patt & clk_mask));
    assign fall    = level && ((samp & clk_mask) == (~clk_patt & clk_mask));
    assign fs_rise = rise && fs && !fs_prev;
    assign at_last = (bit_cnt == BIT_LAST) && (slot_cnt == SLOT_LAST);

`ifdef TDM_FS_CHECK_EN
    logic at_first, at_expect, fs_miss;
    // With a one-bit delay the fs rise lands on the last bit of the previous frame.
    assign at_first  = (bit_cnt == '0) && (slot_cnt == '0);
    assign at_expect = dly ? at_last : at_first;
    assign fs_bad    = (state == RUN) && fs_rise && !at_expect;
    assign fs_miss   = (state == RUN) && rise && !fs_rise && at_expect;
`else
    assign fs_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SYNC;
            SYNC:    if (fs_rise) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_comb begin
        restart     = ((state == SYNC) && fs_rise) || fs_bad;
        capture     = (restart && !dly) || ((state == RUN) && rise && !fs_bad);
        done        = (state == RUN) && rise && !fs_bad && at_last;
        bit_base    = restart ? '0 : bit_cnt;
        slot_base   = restart ? '0 : slot_cnt;
        shadow_base = restart ? '0 : shadow;
        bit_nxt     = bit_base;
        slot_nxt    = slot_base;
        shadow_nxt  = shadow_base;
        if (capture) begin
            // Shifting MSB-first leaves slot 0 in the top bits once the frame is full.
            if (32'(bit_base) < DATA_W) shadow_nxt = FW'({shadow_base, tdmin});
            if (bit_base == BIT_LAST) begin
                bit_nxt  = '0;
                slot_nxt = (slot_base == SLOT_LAST) ? '0 : slot_base + 1'b1;
            end else begin
                bit_nxt = bit_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samp    <= '0;
            level   <= 1'b0;
            fs_prev <= 1'b0;
        end else begin
            samp <= EDGE_W'({samp, sclk});
            if (rise)      level <= 1'b1;
            else if (fall) level <= 1'b0;
            if (rise) fs_prev <= fs;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly        <= 1'b0;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overrun    <= 1'b0;
        end else if (!enable) begin
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE) dly <= fs_delay;
            bit_cnt    <= bit_nxt;
            slot_cnt   <= slot_nxt;
            shadow     <= shadow_nxt;
            frame_done <= done;
            overrun    <= 1'b0;
            if (frame_done) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_data  <= shadow;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TDM_FS_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) frame_err <= 1'b0;
        else       frame_err <= enable && (fs_bad || fs_miss);
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_deser.sv
// tb/tb_tdm_deser.sv - scoreboard bench for tdm_deser (sclk = clk/16).
module tb_tdm_deser;
    localparam int CH = 8, SW = 32, DW = 24, EW = 8, FW = CH * DW;

    logic          clk = 1'b0;
    logic          rstn, enable, fs_delay, sclk, fs, tdmin;
    logic [EW-1:0] clk_patt, clk_mask;
    logic          out_valid, out_ready, overrun, frame_err;
    logic [FW-1:0] out_data;

    logic [FW-1:0] exp_q[$];
    int n_cmp = 0, n_bad = 0, ovr_cnt = 0, ferr_cnt = 0;

    always #5 clk = ~clk;

    tdm_deser #(.CHANNELS(CH), .SLOT_W(SW), .DATA_W(DW), .EDGE_W(EW)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .fs_delay(fs_delay),
        .clk_patt(clk_patt), .clk_mask(clk_mask), .sclk(sclk), .fs(fs),
        .tdmin(tdmin), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overrun(overrun), .frame_err(frame_err)
    );

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (overrun)   ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got %h with no frame expected", out_data);
                end else begin
                    chk("frame", out_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic fbit(input logic [23:0] base, input int i);
        logic [31:0] w;
        w = {base + 24'(i / SW), 8'hFF};
        return w[31 - (i % SW)];
    endfunction

    function automatic logic [FW-1:0] fexp(input logic [23:0] base);
        logic [FW-1:0] r;
        for (int k = 0; k < CH; k++) r[(CH-1-k)*DW +: DW] = base + 24'(k);
        return r;
    endfunction

    // Rise is seen 4 clks after sclk goes high; out_valid follows 2 edges later.
    task automatic send_bit(input logic f, input logic d, input bit lat);
        sclk = 1'b0; fs = f; tdmin = d;
        tick(8);
        sclk = 1'b1;
        if (lat) begin
            tick(5);
            @(negedge clk);
            chk("latency_early", FW'(out_valid), FW'(0));
            tick(1);
            @(negedge clk);
            chk("latency", FW'(out_valid), FW'(1));
            tick(2);
        end else begin
            tick(8);
        end
    endtask

    task automatic send_frame(input logic [23:0] base, input bit dly, input int from, input int upto,
                              input int extra_fs, input bit lat);
        logic f;
        for (int i = from; i < upto; i++) begin
            f = dly ? (i == SW*CH-1) : (i == 0);
            if (i == extra_fs) f = 1'b1;
            send_bit(f, fbit(base, i), lat && (i == SW*CH-1));
        end
    endtask

    task automatic preamble();
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick(1);
        chk(name, FW'(exp_q.size()), FW'(0));
    endtask

    initial begin
        int ovr0, ferr0;
        rstn = 1'b0; enable = 1'b0; fs_delay = 1'b1; sclk = 1'b0; fs = 1'b0; tdmin = 1'b0;
        out_ready = 1'b1; clk_patt = 8'h0F; clk_mask = 8'hFF;
        tick(3);
        chk("reset_valid", FW'(out_valid), FW'(0));
        chk("reset_data", out_data, FW'(0));
        chk("reset_overrun", FW'(overrun), FW'(0));
        chk("reset_frame_err", FW'(frame_err), FW'(0));
        rstn = 1'b1;
        tick(2);

        // Basic, fs one bit ahead of slot 0
        enable = 1'b1;
        tick(2);
        preamble();
        exp_q.push_back(fexp(24'hA50000));
        send_frame(24'hA50000, 1'b1, 0, SW*CH, -1, 1'b1);
        exp_q.push_back(fexp(24'hC30000));
        send_frame(24'hC30000, 1'b1, 0, SW*CH, -1, 1'b0);
        drain("drain_basic");

        // fs coincident with bit 0
        enable = 1'b0;
        tick(2);
        fs_delay = 1'b0;
        enable = 1'b1;
        tick(2);
        send_bit(1'b0, 1'b0, 1'b0);
        exp_q.push_back(fexp(24'hA50000));
        send_frame(24'hA50000, 1'b0, 0, SW*CH, -1, 1'b0);
        drain("drain_delay0");

        // Backpressure across two frames
        out_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(fexp(24'h111100));
        send_frame(24'h111100, 1'b0, 0, SW*CH, -1, 1'b0);
        send_frame(24'h222200, 1'b0, 0, SW*CH, -1, 1'b0);
        tick(4);
        chk("overrun_count", FW'(ovr_cnt - ovr0), FW'(1));
        chk("held_valid", FW'(out_valid), FW'(1));
        chk("held_data", out_data, fexp(24'h111100));
        out_ready = 1'b1;
        drain("drain_backpressure");

        // Disable at bit 100, re-enable with one-bit delay
        send_frame(24'h333300, 1'b0, 0, 100, -1, 1'b0);
        enable = 1'b0;
        tick(2);
        fs_delay = 1'b1;
        enable = 1'b1;
        tick(2);
        send_frame(24'h333300, 1'b0, 100, SW*CH, -1, 1'b0);
        preamble();
        exp_q.push_back(fexp(24'h444400));
        send_frame(24'h444400, 1'b1, 0, SW*CH, -1, 1'b0);
        drain("drain_reenable");

        // Asynchronous reset mid-frame
        send_frame(24'h555500, 1'b1, 0, 50, -1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_valid", FW'(out_valid), FW'(0));
        chk("async_data", out_data, FW'(0));
        chk("async_overrun", FW'(overrun), FW'(0));
        chk("async_frame_err", FW'(frame_err), FW'(0));
        tick(2);
        rstn = 1'b1;
        tick(2);
        preamble();
        exp_q.push_back(fexp(24'h666600));
        send_frame(24'h666600, 1'b1, 0, SW*CH, -1, 1'b0);
        drain("drain_after_reset");

`ifdef TDM_FS_CHECK_EN
        chk("frame_err_none", FW'(ferr_cnt), FW'(0));
        ferr0 = ferr_cnt;
        send_frame(24'h777700, 1'b1, 0, SW*CH, 40, 1'b0);
        exp_q.push_back(fexp(24'h888800));
        send_frame(24'h888800, 1'b1, 0, SW*CH, -1, 1'b0);
        drain("drain_realign");
        chk("frame_err_pulses", FW'(ferr_cnt - ferr0), FW'(2));
`else
        ferr0 = 0;
        chk("frame_err_tied", FW'(ferr_cnt - ferr0), FW'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
